// File: rtl/irq_controller.sv
// irq_controller: 16-line interrupt controller for the Nandy CPU.
// Rising edges on irq_in set bits in a pending register. A software mask gates
// which pending lines can be selected. The highest-numbered active line is
// presented to the CPU through a req/ack handshake. No further request is
// presented until the CPU signals end-of-interrupt (eoi).
module irq_controller #(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] VEC_BASE   = WIDTH'('h0040),
  parameter logic [WIDTH-1:0] VEC_STRIDE = WIDTH'('h0004)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      irq_in,
  input  logic             mask_wr,
  input  logic [15:0]      mask_wdata,
  output logic [15:0]      mask,
  output logic [15:0]      pending,
  output logic             irq_req,
  output logic [3:0]       irq_id,
  output logic [WIDTH-1:0] irq_vec,
  input  logic             irq_ack,
  input  logic             eoi,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [15:0] pending_reg;
  logic [15:0] pending_next;
  logic [15:0] mask_reg;
  logic [15:0] mask_next;
  logic [15:0] irq_in_q_reg;
  logic [3:0]  irq_id_reg;
  logic [3:0]  irq_id_next;

  logic [15:0] rise;
  logic [15:0] clr;
  logic [15:0] active;
  logic [3:0]  sel;
  logic        any_active;
  logic        clr_en;

  // Per-line edge detect and pending update. A new edge on a line wins over
  // the acknowledge clear of that same line, so a request is never lost.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_line
      assign rise[gi]         = irq_in[gi] & ~irq_in_q_reg[gi];
      assign clr[gi]          = clr_en & (irq_id_reg == 4'(gi));
      assign pending_next[gi] = (pending_reg[gi] & ~clr[gi]) | rise[gi];
      assign active[gi]       = pending_reg[gi] & mask_reg[gi];
    end
  endgenerate

  // Mask register load; takes effect on the following cycle's selection.
  assign mask_next = mask_wr ? mask_wdata : mask_reg;

  // 16:4 priority encode, bit 15 has the highest priority (last match wins).
  always_comb begin
    sel        = 4'd0;
    any_active = |active;
    for (int i = 0; i < 16; i++) begin
      if (active[i]) begin
        sel = 4'(i);
      end
    end
  end

  // Handshake FSM next-state logic; irq_id only changes when leaving IDLE.
  always_comb begin
    state_next  = state_reg;
    irq_id_next = irq_id_reg;
    clr_en      = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (any_active) begin
          state_next  = ST_REQ;
          irq_id_next = sel;
        end
      end
      ST_REQ: begin
        // ack takes precedence; a simultaneous eoi is meaningless here
        if (irq_ack) begin
          state_next = ST_SERVICE;
          clr_en     = 1'b1;
        end
      end
      ST_SERVICE: begin
        if (eoi) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, pending, mask, edge-detect and id registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      pending_reg  <= 16'h0000;
      mask_reg     <= 16'h0000;
      irq_in_q_reg <= 16'h0000;
      irq_id_reg   <= 4'd0;
    end else begin
      state_reg    <= state_next;
      pending_reg  <= pending_next;
      mask_reg     <= mask_next;
      irq_in_q_reg <= irq_in;
      irq_id_reg   <= irq_id_next;
    end
  end

  // Outputs decoded purely from registered state and id.
  assign mask    = mask_reg;
  assign pending = pending_reg;
  assign irq_id  = irq_id_reg;
  assign irq_req = (state_reg == ST_REQ);
  assign busy    = (state_reg == ST_SERVICE);
  assign irq_vec = VEC_BASE + WIDTH'(irq_id_reg) * VEC_STRIDE;

endmodule

// File: tb/tb_irq_controller.sv
// Directed testbench for irq_controller with hand-computed expected values.
module tb_irq_controller;

  logic        clk;
  logic        rst_n;
  logic [15:0] irq_in;
  logic        mask_wr;
  logic [15:0] mask_wdata;
  logic [15:0] mask;
  logic [15:0] pending;
  logic        irq_req;
  logic [3:0]  irq_id;
  logic [15:0] irq_vec;
  logic        irq_ack;
  logic        eoi;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  irq_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_in     (irq_in),
    .mask_wr    (mask_wr),
    .mask_wdata (mask_wdata),
    .mask       (mask),
    .pending    (pending),
    .irq_req    (irq_req),
    .irq_id     (irq_id),
    .irq_vec    (irq_vec),
    .irq_ack    (irq_ack),
    .eoi        (eoi),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // single comparison point: count and report
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // advance one clock; sample/drive 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mask(input logic [15:0] m);
    mask_wr    = 1'b1;
    mask_wdata = m;
    tick();
    mask_wr    = 1'b0;
  endtask

  // check the presented request: req high, id and vector as given
  task automatic chk_req(input string tag, input logic [3:0] id, input logic [15:0] vec);
    chk({tag, "_req"}, 32'(irq_req), 32'd1);
    chk({tag, "_id"},  32'(irq_id),  32'(id));
    chk({tag, "_vec"}, 32'(irq_vec), 32'(vec));
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic do_eoi();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  // global time bound so the run can never hang
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n      = 1'b0;
    irq_in     = 16'h0000;
    mask_wr    = 1'b0;
    mask_wdata = 16'h0000;
    irq_ack    = 1'b0;
    eoi        = 1'b0;
    tick();
    tick();
    chk("rst_mask",    32'(mask),    32'h0000);
    chk("rst_pending", 32'(pending), 32'h0000);
    chk("rst_req",     32'(irq_req), 32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_id",      32'(irq_id),  32'd0);
    chk("rst_vec",     32'(irq_vec), 32'h0040);
    rst_n = 1'b1;
    tick();

    // 1) single enabled line, two-cycle latency
    write_mask(16'h0008);
    chk("t1_mask", 32'(mask), 32'h0008);
    irq_in = 16'h0008;
    tick();
    chk("t1_pend", 32'(pending), 32'h0008);
    chk("t1_req_early", 32'(irq_req), 32'd0);
    irq_in = 16'h0000;
    tick();
    chk_req("t1", 4'd3, 16'h004C);
    do_ack();
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_req_svc", 32'(irq_req), 32'd0);
    chk("t1_pend_clr", 32'(pending), 32'h0000);
    do_eoi();
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // 2) simultaneous edges, higher id wins
    write_mask(16'hFFFF);
    irq_in = 16'h0204;
    tick();
    chk("t2_pend", 32'(pending), 32'h0204);
    irq_in = 16'h0000;
    tick();
    chk_req("t2a", 4'd9, 16'h0064);
    do_ack();
    chk("t2_pend_after_ack", 32'(pending), 32'h0004);
    do_eoi();
    chk("t2_req_after_eoi", 32'(irq_req), 32'd0);
    tick();
    chk_req("t2b", 4'd2, 16'h0048);
    do_ack();
    do_eoi();

    // 3) masked line pends but does not request until enabled
    write_mask(16'h0000);
    irq_in = 16'h0020;
    tick();
    irq_in = 16'h0000;
    tick();
    tick();
    chk("t3_pend", 32'(pending), 32'h0020);
    chk("t3_req_masked", 32'(irq_req), 32'd0);
    write_mask(16'h0020);
    chk("t3_req_mask_cycle", 32'(irq_req), 32'd0);
    tick();
    chk_req("t3", 4'd5, 16'h0054);
    do_ack();
    do_eoi();

    // 4) re-trigger of the serviced line waits for eoi
    write_mask(16'h0010);
    irq_in = 16'h0010;
    tick();
    irq_in = 16'h0000;
    tick();
    chk_req("t4a", 4'd4, 16'h0050);
    do_ack();
    irq_in = 16'h0010;
    tick();
    irq_in = 16'h0000;
    chk("t4_pend_svc", 32'(pending), 32'h0010);
    tick();
    tick();
    chk("t4_req_svc", 32'(irq_req), 32'd0);
    chk("t4_busy_svc", 32'(busy), 32'd1);
    do_eoi();
    chk("t4_req_eoi", 32'(irq_req), 32'd0);
    tick();
    chk_req("t4b", 4'd4, 16'h0050);

    // 5) edge on the acked line in the ack cycle keeps pending set
    irq_ack = 1'b1;
    irq_in  = 16'h0010;
    tick();
    irq_ack = 1'b0;
    irq_in  = 16'h0000;
    chk("t5_busy", 32'(busy), 32'd1);
    chk("t5_pend_reset", 32'(pending), 32'h0010);
    do_eoi();
    tick();
    chk_req("t5b", 4'd4, 16'h0050);
    do_ack();
    do_eoi();
    chk("t5_pend_zero", 32'(pending), 32'h0000);
    // ack/eoi in IDLE are ignored
    irq_ack = 1'b1;
    eoi     = 1'b1;
    tick();
    irq_ack = 1'b0;
    eoi     = 1'b0;
    chk("t5_idle_req", 32'(irq_req), 32'd0);
    chk("t5_idle_busy", 32'(busy), 32'd0);
    // ack and eoi together in REQ: ack only
    write_mask(16'hFFFF);
    irq_in = 16'h0080;
    tick();
    irq_in = 16'h0000;
    tick();
    chk_req("t5c", 4'd7, 16'h005C);
    irq_ack = 1'b1;
    eoi     = 1'b1;
    tick();
    irq_ack = 1'b0;
    eoi     = 1'b0;
    chk("t5_acketc_busy", 32'(busy), 32'd1);
    do_eoi();
    chk("t5_acketc_idle", 32'(busy), 32'd0);

    // 6) async reset during REQ, line held high through reset
    irq_in = 16'h0040;
    tick();
    tick();
    chk_req("t6a", 4'd6, 16'h0058);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req",  32'(irq_req), 32'd0);
    chk("t6_rst_pend", 32'(pending), 32'h0000);
    chk("t6_rst_mask", 32'(mask),    32'h0000);
    chk("t6_rst_id",   32'(irq_id),  32'd0);
    chk("t6_rst_vec",  32'(irq_vec), 32'h0040);
    chk("t6_rst_busy", 32'(busy),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    write_mask(16'hFFFF);
    chk("t6_pend_held", 32'(pending), 32'h0040);
    tick();
    chk_req("t6b", 4'd6, 16'h0058);
    irq_in = 16'h0000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
